apb_slave_mem: RTL and testbench
================================

# apb_slave_mem

APB3 completer that terminates the bus driven by the testbench's APB driver: a word-organized register memory with programmable wait states and error response. It sits on the far end of the `paddr/pwrite/psel/penable/pwdata/prdata` bus, adding `pready` and `pslverr` outputs. It serves as the DUT for the APB UVM environment and as a reference memory model for later peripherals.

## Interface
- `DEPTH`, 64: number of 32-bit words; legal range 1..64.
- `WAIT_CYCLES`, 0: wait states inserted per transfer; legal range 0..15.
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `paddr`  in  8  byte address; word index = `paddr[7:2]`.
- `pwrite`  in  1  1 = write, 0 = read.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase strobe.
- `pwdata`  in  32  write data.
- `prdata`  out  32  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer-complete strobe, registered.
- `pslverr`  out  1  error response, valid only while `pready`=1.

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: on an edge with `psel`=1 and `penable`=0 (setup), latch `paddr`, `pwrite`, and `pwdata`. Load wait counter with `WAIT_CYCLES` and go to ACCESS.
  - If `WAIT_CYCLES`=0, go straight to DONE with `pready`=1 registered, so `pready` is high in the first access cycle.
- IDLE with `penable`=1 and no preceding setup: protocol violation. Ignore it: no write, `pready` stays 0.
- ACCESS: decrement the counter each edge while `psel`=1.
  - When the counter reaches 1, register `pready`=1 and go to DONE.
  - If `psel`=0 in any cycle, abort: return to IDLE, no write, `pready`=0.
- DONE (`pready`=1): the transfer completes at this edge if `psel`=1 and `penable`=1.
  - Write without error: `mem[idx]` <= latched `pwdata`.
  - Next state: `pready` <= 0, `pslverr` <= 0, `prdata` <= 0.
  - If the edge also shows `psel`=1 and `penable`=0, that is a back-to-back setup; it is not possible in the same edge. The next setup is taken from IDLE on the following edge.
  - If the master dropped `psel` during DONE, return to IDLE with no write.
- Read data: `prdata` is loaded with `mem[idx]` in the same edge that sets `pready`=1. On error `prdata` is loaded with 32'h0.
- Error condition (evaluated on latched address):
  - `paddr[1:0]` != 0, or
  - `paddr[7:2]` >= `DEPTH`.
  - When the condition holds, `pslverr`=1 alongside `pready`. An erroring write leaves memory unchanged.
- Write data and address are taken from the setup-cycle latch. Changes on the bus during ACCESS are ignored.
- Memory is read-after-write coherent: a read following a completed write to the same word returns the new value.

## Timing
- Reset (`rst_n`=0 at an edge):
  - State → IDLE.
  - `prdata`=0, `pready`=0, `pslverr`=0.
  - All `DEPTH` words cleared to 0.
  - Takes effect at that edge. A transfer in flight is dropped: no write, no `pready`.
- Latency, setup edge to `pready` high: 1 + `WAIT_CYCLES` cycles.
  - Total transfer is 2 + `WAIT_CYCLES` cycles including setup, e.g. 2 cycles for `WAIT_CYCLES`=0.
- `pready` is high for exactly one cycle per completed transfer.
- The memory write commits on the completing edge (`psel`&`penable`&`pready`).
- Minimum gap between transfers: one IDLE cycle is not required. A setup may be presented on the cycle immediately after completion and is accepted from IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Simultaneous reset and completing edge: reset wins, no write.

## Test plan
- Reset check: hold `rst_n`=0 for 2 cycles, then read `paddr`=0x00. Expect `prdata`=0, `pready` high 1 cycle after setup, `pslverr`=0.
- Write/read, `WAIT_CYCLES`=0: write 0xDEADBEEF to 0x10, then read 0x10. Expect `prdata`=0xDEADBEEF, each transfer 2 cycles, `pslverr`=0.
- Wait states, `WAIT_CYCLES`=3: write 0x12345678 to 0xFC (`DEPTH`=64). Expect `pready` low for 3 access cycles, high on the 4th; read-back matches.
- Error:
  - Write 0xFFFFFFFF to misaligned 0x11. Expect `pslverr`=1 with `pready`.
  - Then read 0x10. Expect the prior value 0xDEADBEEF is unchanged.
  - With `DEPTH`=16, reading 0x40 gives `pslverr`=1 and `prdata`=0.
- Abort and reset mid-transfer, `WAIT_CYCLES`=2:
  - Drop `psel` during ACCESS of a write of 0xA5A5A5A5 to 0x20. Expect no `pready`; read 0x20 returns the old value.
  - Repeat with `rst_n`=0 mid-access. Expect all outputs 0 and mem[8]=0.
- Back-to-back: write 0x1 to 0x00, immediately followed by setup of a read of 0x00. Expect the read returns 0x1 with no intervening idle cycle required.

Source files
------------

// File: rtl/apb_slave_mem.sv
// -----------------------------------------------------------------------------
// apb_slave_mem
//
// APB3 completer backed by a word-organized register memory. Each transfer
// takes a configurable number of wait states, and the memory flags misaligned
// or out-of-range addresses with an error response.
//
// Parameters
//   DEPTH        number of 32-bit words, 1..64
//   WAIT_CYCLES  wait states inserted per transfer, 0..15
//
// Ports
//   clk      in   sole clock, rising edge
//   rst_n    in   synchronous active-low reset; clears state, outputs, memory
//   paddr    in   byte address, word index = paddr[7:2]
//   pwrite   in   1 = write, 0 = read
//   psel     in   slave select
//   penable  in   access-phase strobe
//   pwdata   in   write data
//   prdata   out  read data, valid while pready=1 on a read (else 0)
//   pready   out  transfer-complete strobe, one cycle per completed transfer
//   pslverr  out  error response, valid while pready=1
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
// -----------------------------------------------------------------------------
module apb_slave_mem #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  paddr,
  input  logic        pwrite,
  input  logic        psel,
  input  logic        penable,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr
);

  // Index width needed to address DEPTH words (at least one bit).
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e      state_q;
  logic [7:0]  addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [3:0]  cnt_q;
  logic [31:0] prdata_q;
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] mem_q [DEPTH];

  // Response decode. While idle the address has not been latched yet, but
  // with zero wait states the response is produced on the setup edge itself,
  // so decode from the bus in that state and from the latch otherwise.
  logic [7:0]    addr_d;
  logic          err_d;
  logic [31:0]   rdata_d;
  logic [AW-1:0] rd_idx;
  logic [AW-1:0] wr_idx;
  logic          setup;

  assign setup  = psel && !penable;
  assign addr_d = (state_q == S_IDLE) ? paddr : addr_q;
  // Range check is done on a 7-bit value so DEPTH=64 compares correctly.
  assign err_d  = (addr_d[1:0] != 2'b00) ||
                  ({1'b0, addr_d[7:2]} >= 7'(DEPTH));
  assign rd_idx = addr_d[2 +: AW];
  assign wr_idx = addr_q[2 +: AW];

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    rdata_d = '0;
    if (!err_d) begin
      rdata_d = mem_q[rd_idx];
    end
  end

  // NOTE: all sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of every other flop, independent of ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      // NOTE: the memory is built from flops and must read back as zero after
      // reset, so it is cleared here; a RAM macro could not be reset this way.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          // An access phase with no preceding setup is a protocol violation
          // and is ignored: only a setup cycle starts a transfer.
          if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            cnt_q   <= WAIT_INIT;
            if (WAIT_CYCLES == 0) begin
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= (pwrite || err_d) ? 32'h0 : rdata_d;
              state_q   <= S_DONE;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end

        S_ACCESS: begin
          if (!psel) begin
            // Master abandoned the transfer: nothing is written or reported.
            state_q <= S_IDLE;
          end else if (cnt_q == 4'd1) begin
            pready_q  <= 1'b1;
            pslverr_q <= err_d;
            prdata_q  <= (write_q || err_d) ? 32'h0 : rdata_d;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end

        S_DONE: begin
          // pslverr_q still holds this transfer's error flag, so it gates the
          // write. A dropped psel here leaves memory untouched.
          if (psel && penable && write_q && !pslverr_q) begin
            mem_q[wr_idx] <= wdata_q;
          end
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          prdata_q  <= '0;
          state_q   <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave_mem.sv
// -----------------------------------------------------------------------------
// tb_apb_slave_mem
//
// Three instances share one APB bus (each with its own psel):
//   dut 0: DEPTH=64, WAIT_CYCLES=0
//   dut 1: DEPTH=64, WAIT_CYCLES=3
//   dut 2: DEPTH=16, WAIT_CYCLES=2
// A per-instance memory model computes expected responses; they are queued
// when a transfer is driven and compared when pready rises.
// -----------------------------------------------------------------------------
module tb_apb_slave_mem;

  localparam int NDUT = 3;
  localparam int WAITS  [NDUT] = '{0, 3, 2};
  localparam int DEPTHS [NDUT] = '{64, 64, 16};

  typedef struct {
    bit          err;
    bit          wr;
    logic [31:0] rdata;
    int          lat;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic        psel_w    [NDUT];
  logic [31:0] prdata_w  [NDUT];
  logic        pready_w  [NDUT];
  logic        pslverr_w [NDUT];

  logic [31:0] model [NDUT][64];
  exp_t        sb [$];
  int          tests_run = 0;
  int          tests_failed = 0;

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_w[0]),
    .penable(penable), .pwdata(pwdata), .prdata(prdata_w[0]),
    .pready(pready_w[0]), .pslverr(pslverr_w[0])
  );

  apb_slave_mem #(.DEPTH(64), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_w[1]),
    .penable(penable), .pwdata(pwdata), .prdata(prdata_w[1]),
    .pready(pready_w[1]), .pslverr(pslverr_w[1])
  );

  apb_slave_mem #(.DEPTH(16), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .pwrite(pwrite), .psel(psel_w[2]),
    .penable(penable), .pwdata(pwdata), .prdata(prdata_w[2]),
    .pready(pready_w[2]), .pslverr(pslverr_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 64; i++)
        model[d][i] = '0;
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    check({tag, " prdata"},  prdata_w[d],  32'h0);
    check({tag, " pready"},  32'(pready_w[d]),  32'h0);
    check({tag, " pslverr"}, 32'(pslverr_w[d]), 32'h0);
  endtask

  // One complete APB transfer on instance d. Returns with psel low, right
  // after the completing edge, so a following call forms a back-to-back pair.
  task automatic xfer(input string tag, input int d, input bit wr,
                      input logic [7:0] a, input logic [31:0] wd);
    exp_t e;
    int   idx;
    int   cycles;
    bit   err;
    idx = int'(a[7:2]);
    err = (a[1:0] != 2'b00) || (idx >= DEPTHS[d]);
    e.err   = err;
    e.wr    = wr;
    e.lat   = WAITS[d] + 1;
    e.rdata = (wr || err) ? 32'h0 : model[d][idx];
    if (wr && !err) model[d][idx] = wd;
    sb.push_back(e);

    // Setup phase.
    paddr = a; pwrite = wr; pwdata = wd; penable = 1'b0; psel_w[d] = 1'b1;
    tick();
    cycles = 1;
    // Access phase; scramble address/data, which the slave must ignore.
    penable = 1'b1;
    paddr   = a ^ 8'h04;
    pwdata  = ~wd;
    while (pready_w[d] !== 1'b1 && cycles < 32) begin
      tick();
      cycles++;
    end
    e = sb.pop_front();
    if (pready_w[d] !== 1'b1) begin
      check({tag, " pready timeout"}, 32'(pready_w[d]), 32'h1);
      psel_w[d] = 1'b0; penable = 1'b0;
      return;
    end
    check({tag, " latency"}, 32'(cycles), 32'(e.lat));
    check({tag, " pslverr"}, 32'(pslverr_w[d]), 32'(e.err));
    if (!e.wr) check({tag, " prdata"}, prdata_w[d], e.rdata);
    tick();  // completing edge
    psel_w[d] = 1'b0; penable = 1'b0;
    check({tag, " pready one cycle"}, 32'(pready_w[d]), 32'h0);
  endtask

  initial begin
    rst_n = 1'b0; paddr = '0; pwrite = 1'b0; penable = 1'b0; pwdata = '0;
    for (int d = 0; d < NDUT; d++) psel_w[d] = 1'b0;
    clear_model();

    // Reset: two cycles low, all outputs zero.
    tick(); tick();
    for (int d = 0; d < NDUT; d++) check_idle_outputs($sformatf("reset dut%0d", d), d);
    rst_n = 1'b1;
    tick();

    // Zero wait states.
    xfer("w0 rd 0x00", 0, 1'b0, 8'h00, 32'h0);
    xfer("w0 wr 0x10", 0, 1'b1, 8'h10, 32'hDEADBEEF);
    xfer("w0 rd 0x10", 0, 1'b0, 8'h10, 32'h0);

    // Access phase without setup is ignored: no pready, no write.
    paddr = 8'h10; pwrite = 1'b1; pwdata = 32'h0BADF00D; psel_w[0] = 1'b1; penable = 1'b1;
    tick();
    check("no-setup pready", 32'(pready_w[0]), 32'h0);
    tick();
    check("no-setup pready 2", 32'(pready_w[0]), 32'h0);
    psel_w[0] = 1'b0; penable = 1'b0;
    tick();
    xfer("no-setup rd 0x10", 0, 1'b0, 8'h10, 32'h0);

    // Misaligned write errors and leaves memory unchanged.
    xfer("w0 wr misaligned", 0, 1'b1, 8'h11, 32'hFFFFFFFF);
    xfer("w0 rd after err", 0, 1'b0, 8'h10, 32'h0);

    // Three wait states, top word.
    xfer("w3 wr 0xFC", 1, 1'b1, 8'hFC, 32'h12345678);
    xfer("w3 rd 0xFC", 1, 1'b0, 8'hFC, 32'h0);

    // DEPTH=16: out-of-range and last-word boundaries.
    xfer("d16 rd 0x40", 2, 1'b0, 8'h40, 32'h0);
    xfer("d16 wr 0x3C", 2, 1'b1, 8'h3C, 32'hCAFE0001);
    xfer("d16 rd 0x3C", 2, 1'b0, 8'h3C, 32'h0);
    xfer("d16 wr 0x20", 2, 1'b1, 8'h20, 32'h11111111);

    // Abort: psel dropped during access.
    paddr = 8'h20; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; penable = 1'b0; psel_w[2] = 1'b1;
    tick();
    penable = 1'b1;
    tick();
    check("abort pready acc", 32'(pready_w[2]), 32'h0);
    psel_w[2] = 1'b0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("abort pready idle%0d", i), 32'(pready_w[2]), 32'h0);
    end
    xfer("abort rd 0x20", 2, 1'b0, 8'h20, 32'h0);

    // Reset mid-access: dropped transfer, outputs and memory cleared.
    paddr = 8'h20; pwrite = 1'b1; pwdata = 32'hA5A5A5A5; penable = 1'b0; psel_w[2] = 1'b1;
    tick();
    penable = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    check_idle_outputs("mid-reset dut2", 2);
    clear_model();
    rst_n = 1'b1; psel_w[2] = 1'b0; penable = 1'b0;
    tick();
    check_idle_outputs("post-reset dut2", 2);
    xfer("mid-reset rd 0x20", 2, 1'b0, 8'h20, 32'h0);
    xfer("mid-reset rd dut0 0x10", 0, 1'b0, 8'h10, 32'h0);

    // Back-to-back write then read with no idle cycle between.
    xfer("b2b wr 0x00", 0, 1'b1, 8'h00, 32'h00000001);
    xfer("b2b rd 0x00", 0, 1'b0, 8'h00, 32'h0);
    xfer("b2b wr 0x04", 0, 1'b1, 8'h04, 32'h89ABCDEF);
    xfer("b2b rd 0x04", 0, 1'b0, 8'h04, 32'h0);

    check("scoreboard empty", 32'(sb.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
